// File: rtl/conv1_frame_loader.sv
// Streams 25 filter bytes, one bias byte and a 28x28 image into registered
// operand buses for conv1; the image sits centred in a zero-bordered 32x32 tensor.
module conv1_frame_loader (
    input  logic             clk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iValid,
    input  logic [7:0]       iData,
    output logic             oReady,
    output logic [8191:0]    tensor_out,
    output logic [199:0]     filter_out,
    output logic [7:0]       bias_out,
    output logic             oDone,
    output logic             oBusy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILTER = 3'd1,
        BIAS   = 3'd2,
        PIXEL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic        done_q;
    logic [4:0]  filt_cnt_q;
    logic [4:0]  row_q;
    logic [4:0]  col_q;
    logic [7:0]  filter_q [0:24];
    logic [7:0]  bias_q;
    logic [7:0]  img_q    [0:27][0:27];
    logic        accept;

    assign accept = iValid && ready_q;

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            filt_cnt_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            bias_q     <= '0;
            for (int i = 0; i < 25; i++) begin
                filter_q[i] <= '0;
            end
            for (int r = 0; r < 28; r++) begin
                for (int c = 0; c < 28; c++) begin
                    img_q[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // Storage is kept across frames; only the counters restart.
                    if (iStart) begin
                        state_q    <= FILTER;
                        ready_q    <= 1'b1;
                        done_q     <= 1'b0;
                        filt_cnt_q <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                    end
                end
                FILTER: begin
                    if (accept) begin
                        filter_q[filt_cnt_q] <= iData;
                        if (filt_cnt_q == 5'd24) begin
                            filt_cnt_q <= '0;
                            state_q    <= BIAS;
                        end else begin
                            filt_cnt_q <= filt_cnt_q + 5'd1;
                        end
                    end
                end
                BIAS: begin
                    if (accept) begin
                        bias_q  <= iData;
                        state_q <= PIXEL;
                    end
                end
                PIXEL: begin
                    if (accept) begin
                        img_q[row_q][col_q] <= iData;
                        if (col_q == 5'd27) begin
                            col_q <= '0;
                            if (row_q == 5'd27) begin
                                row_q   <= '0;
                                state_q <= DONE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                row_q <= row_q + 5'd1;
                            end
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oReady   = ready_q;
    assign oBusy    = ready_q;
    assign oDone    = done_q;
    assign bias_out = bias_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_filter
            assign filter_out[gi*8 +: 8] = filter_q[gi];
        end
        // Two-element border on each side is hard-wired zero.
        for (gi = 0; gi < 32; gi++) begin : g_row
            for (gj = 0; gj < 32; gj++) begin : g_col
                if (gi >= 2 && gi <= 29 && gj >= 2 && gj <= 29) begin : g_in
                    assign tensor_out[(gi*32+gj)*8 +: 8] = img_q[gi-2][gj-2];
                end else begin : g_pad
                    assign tensor_out[(gi*32+gj)*8 +: 8] = 8'h00;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_conv1_frame_loader.sv
// Directed bench for conv1_frame_loader: full frames with and without input
// gaps, dropped bytes outside loading states, ignored restarts, async reset.
module tb_conv1_frame_loader;

    logic           clk = 1'b0;
    logic           iRst_n = 1'b1;
    logic           iStart = 1'b0;
    logic           iValid = 1'b0;
    logic [7:0]     iData = 8'h00;
    logic           oReady;
    logic [8191:0]  tensor_out;
    logic [199:0]   filter_out;
    logic [7:0]     bias_out;
    logic           oDone;
    logic           oBusy;

    conv1_frame_loader dut (
        .clk        (clk),
        .iRst_n     (iRst_n),
        .iStart     (iStart),
        .iValid     (iValid),
        .iData      (iData),
        .oReady     (oReady),
        .tensor_out (tensor_out),
        .filter_out (filter_out),
        .bias_out   (bias_out),
        .oDone      (oDone),
        .oBusy      (oBusy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         not_ready;
    logic [7:0] m_tensor [0:1023];
    logic [7:0] m_filt   [0:24];
    logic [7:0] m_bias;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] elem(input int r, input int c);
        return tensor_out[(r*32+c)*8 +: 8];
    endfunction

    function automatic logic [7:0] filt(input int j);
        return filter_out[j*8 +: 8];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) m_tensor[i] = 8'h00;
        for (int j = 0; j < 25; j++) m_filt[j] = 8'h00;
        m_bias = 8'h00;
    endtask

    task automatic compare_all(input string tag);
        int bad = 0;
        for (int i = 0; i < 1024; i++)
            if (tensor_out[i*8 +: 8] !== m_tensor[i]) bad++;
        for (int j = 0; j < 25; j++)
            if (filt(j) !== m_filt[j]) bad++;
        if (bias_out !== m_bias) bad++;
        check(tag, bad, 0);
    endtask

    task automatic send(input logic [7:0] d, input bit gaps, input bit pulse_start);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                iValid = 1'b0;
                @(negedge clk);
            end
        end
        if (!oReady) not_ready++;
        iValid = 1'b1;
        iData  = d;
        iStart = pulse_start;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // Pixel i carries (i + poff) & 0xFF; filter byte 0 is f0, byte j>0 is j+1.
    task automatic load_frame(input logic [7:0] f0, input logic [7:0] b, input int poff,
                              input bit gaps, input int start_at, input string tag);
        logic [7:0] d;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        check({tag, "_rdy_busy_done_after_start"}, {29'd0, oReady, oBusy, oDone}, 32'b110);
        not_ready = 0;
        for (int j = 0; j < 25; j++) begin
            d = (j == 0) ? f0 : 8'(j + 1);
            m_filt[j] = d;
            send(d, gaps, 1'b0);
        end
        m_bias = b;
        send(b, gaps, 1'b0);
        for (int i = 0; i < 784; i++) begin
            d = 8'(i + poff);
            m_tensor[((i / 28) + 2) * 32 + (i % 28) + 2] = d;
            if (i == 783) check({tag, "_done_before_last"}, {31'd0, oDone}, 0);
            send(d, gaps, i == start_at);
        end
        iValid = 1'b0;
        check({tag, "_ready_during_frame"}, not_ready, 0);
        check({tag, "_done_rdy_busy_after_last"}, {29'd0, oDone, oReady, oBusy}, 32'b100);
    endtask

    task automatic stray_bytes(input string tag, input logic exp_done);
        iValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iData = 8'hE0 + 8'(k);
            @(negedge clk);
        end
        iValid = 1'b0;
        check({tag, "_ready_busy"}, {30'd0, oReady, oBusy}, 0);
        check({tag, "_done"}, {31'd0, oDone}, {31'd0, exp_done});
        compare_all({tag, "_storage"});
    endtask

    initial begin
        int border_bad;
        clear_model();
        #2 iRst_n = 1'b0;
        #1;
        check("reset_outputs", {29'd0, oReady, oDone, oBusy}, 0);
        compare_all("reset_storage");
        repeat (2) @(negedge clk);
        iRst_n = 1'b1;
        @(negedge clk);

        stray_bytes("idle_valid", 1'b0);

        load_frame(8'd1, 8'h40, 0, 1'b0, -1, "frameA");
        check("A_filter_first", filt(0), 8'd1);
        check("A_filter_last", filter_out[199:192], 8'd25);
        check("A_bias", bias_out, 8'h40);
        check("A_elem_2_2", elem(2, 2), 8'h00);
        check("A_elem_2_3", elem(2, 3), 8'h01);
        check("A_elem_29_29", elem(29, 29), 8'h0F);
        check("A_elem_2_29", elem(2, 29), 8'd27);
        check("A_elem_3_2", elem(3, 2), 8'd28);
        check("A_elem_2_30", elem(2, 30), 8'h00);
        check("A_elem_2_31", elem(2, 31), 8'h00);
        border_bad = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                if ((r < 2 || r > 29 || c < 2 || c > 29) && elem(r, c) !== 8'h00) border_bad++;
        check("A_border_nonzero", border_bad, 0);
        compare_all("A_full");

        stray_bytes("done_valid", 1'b1);

        load_frame(8'h33, 8'h41, 5, 1'b1, 100, "frameB_gaps_restart");
        check("B_filter_first", filt(0), 8'h33);
        check("B_elem_2_2", elem(2, 2), 8'h05);
        compare_all("B_full");

        load_frame(8'hAA, 8'h40, 0, 1'b0, -1, "frameC");
        check("C_filter_first", filt(0), 8'hAA);
        compare_all("C_full");

        // Abort in the middle of the pixel phase with an asynchronous reset.
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        for (int j = 0; j < 26; j++) send(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) send(8'h99, 1'b0, 1'b0);
        #2 iRst_n = 1'b0;
        #1;
        clear_model();
        check("arst_outputs", {29'd0, oReady, oDone, oBusy}, 0);
        compare_all("arst_storage");
        @(negedge clk);
        iValid = 1'b0;
        iRst_n = 1'b1;
        @(negedge clk);
        load_frame(8'd1, 8'h40, 0, 1'b0, -1, "frameD");
        check("D_elem_29_29", elem(29, 29), 8'h0F);
        compare_all("D_full");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv1_frame_loader.md
# conv1_frame_loader

Byte-stream loader that assembles one complete conv1 operand set: 25 filter bytes, 1 bias byte and a 28×28 image, which it places centred in a zero-padded 32×32 tensor. It sits upstream of the conv1 layer engine and fills that engine's `tensor_in`, `filter_in` and `bias_in` buses. It then asserts `oDone` so the controller can enable the convolution. Input uses a valid/ready handshake, one byte per accepted cycle.

## Interface
- No parameters; all dimensions are fixed at 32×32 in, 5×5 filter, 28×28 image, 8-bit elements.
- `clk` in 1: single clock; all state changes on posedge.
- `iRst_n` in 1: asynchronous active-low reset.
- `iStart` in 1: one-cycle pulse; begins loading a new frame when in IDLE or DONE.
- `iValid` in 1: `iData` holds a valid byte.
- `iData` in 8: stream byte (Float8 encoding, passed through unmodified).
- `oReady` out 1: loader accepts a byte this cycle.
- `tensor_out` out 32*32*8: padded image; element (r,c) at bits `[(r*32+c)*8 +: 8]`.
- `filter_out` out 25*8: kernel; element (fr,fc) at bits `[(fr*5+fc)*8 +: 8]`.
- `bias_out` out 8: bias byte.
- `oDone` out 1: complete frame held on outputs.
- `oBusy` out 1: high in FILTER, BIAS or PIXEL.

## Operation
- Stream order per frame: 25 filter bytes in row-major order (fr, then fc), then 1 bias byte, then 784 pixel bytes in row-major order.
- Transfer rule: a byte is accepted when `iValid && oReady` at posedge. No other condition writes storage.
- States and transitions:
  - IDLE → FILTER on `iStart`.
  - FILTER → BIAS after 25th filter byte accepted.
  - BIAS → PIXEL on bias byte accepted.
  - PIXEL → DONE after 784th pixel accepted.
  - DONE → FILTER on `iStart`.
- Storage addressing:
  - Filter byte j (0..24) → `filter_out[j*8 +: 8]`.
  - Pixel counters `row`, `col` run 0..27. Pixel (row, col) → `tensor_out` element (row+2, col+2).
  - `col` wraps 27→0 and increments `row`. No divide/modulo logic.
- Border: rows 0,1,30,31 and cols 0,1,30,31 of `tensor_out` are constant zero. They are never written.
- Between frames the image interior, filter and bias keep the previous frame's values until overwritten byte by byte. `iStart` does not clear them.
- Outputs:
  - `oReady` = 1 exactly in FILTER, BIAS and PIXEL.
  - `oDone` = 1 exactly in DONE.
  - `oBusy` = `oReady`.
- `iStart` during FILTER, BIAS or PIXEL is ignored; the count continues.
- `iStart` together with a handshake in the same cycle: the handshake is processed as in the current state.
- `iValid` while `oReady` = 0: the byte is dropped; no state change.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; `oReady`, `oDone`, `oBusy` = 0.
  - All counters 0.
  - `tensor_out`, `filter_out`, `bias_out` all zero.
- `iStart` at edge k: `oReady` = 1 from after edge k, so the first byte can be accepted at edge k+1.
- Throughput: one byte per cycle when `iValid` is held high. A full frame is 810 accepting edges.
- Final pixel accepted at edge n: after edge n, `oDone` = 1, `oReady` = 0, and the element (29,29) data is visible.
- All outputs are registered. Data written at an edge is visible on `tensor_out`, `filter_out` and `bias_out` immediately after that edge.
- Reset asserted mid-frame: the loader returns to IDLE with zeroed storage. A later `iStart` restarts from filter byte 0.

## Test plan
- Reset, then `iStart`, then stream filter 1..25, bias 0x40, pixels p = i & 0xFF, with `iValid` held high:
  - `filter_out[7:0]` = 1 and `filter_out[199:192]` = 25.
  - `bias_out` = 0x40.
  - Element (2,2) = 0x00 and element (2,3) = 0x01; element (29,29) = 783 & 0xFF = 0x0F.
  - All border bytes are 0.
  - `oDone` rises one cycle after the 810th handshake.
- Random `iValid` gaps (50% duty) over a full frame:
  - Final contents match the gap-free run.
  - `oDone` rises exactly after the 810th accepted byte.
- `iValid` pulses in IDLE and DONE: storage is unchanged and `oReady` stays 0.
- `iStart` pulsed at pixel 100:
  - No restart; the frame completes normally.
  - A second `iStart` in DONE reloads the frame, and a new filter byte 0xAA lands at `filter_out[7:0]`.
- Assert `iRst_n` = 0 mid-PIXEL, asynchronously between edges:
  - Outputs zero without waiting for a clock edge; state is IDLE.
  - The next full frame loads correctly.
- Row wrap: pixel 27 lands at element (2,29) and pixel 28 at element (3,2); elements (2,30) and (2,31) stay 0.
